// File: rtl/wb_vme_strobe_bridge.sv
// rtl/wb_vme_strobe_bridge.sv - Wishbone classic to VME-style strobe/done bridge with Done timeout
module wb_vme_strobe_bridge #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [ADDR_WIDTH:1]   VMEAddr,
    output logic [DATA_WIDTH-1:0] VMEWrData,
    output logic                  VMERdMem,
    output logic                  VMEWrMem,
    input  logic [DATA_WIDTH-1:0] VMERdData,
    input  logic                  VMERdDone,
    input  logic                  VMEWrDone,
    output logic                  timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  abort_q, abort_d;
    logic [ADDR_WIDTH:1]   addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  rd_d, wr_d, ack_d, err_d, to_d;
    logic                  match_done;
    logic [CW-1:0]         cnt_inc;

    assign match_done = we_q ? VMEWrDone : VMERdDone;
    assign cnt_inc    = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        abort_d = abort_q;
        addr_d  = VMEAddr;
        wdata_d = VMEWrData;
        rdata_d = wb_dat_o;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_d  = wb_adr_i;
                    if (wb_we_i) wdata_d = wb_dat_i;
                    we_d    = wb_we_i;
                    abort_d = 1'b0;
                    wr_d    = wb_we_i;
                    rd_d    = ~wb_we_i;
                    state_d = S_STROBE;
                end
            end
            S_STROBE, S_WAIT: begin
                // A master that drops cyc mid-access loses its ack/err for good.
                if (!wb_cyc_i) abort_d = 1'b1;
                cnt_d = (state_q == S_STROBE) ? '0 : cnt_inc;
                if (match_done) begin
                    state_d = S_RESP;
                    ack_d   = wb_cyc_i && !abort_q;
                    if (!we_q) rdata_d = VMERdData;
                end else if (state_q == S_STROBE) begin
                    state_d = S_WAIT;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    state_d = S_RESP;
                    err_d   = wb_cyc_i && !abort_q;
                    to_d    = 1'b1;
                    rdata_d = '0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            abort_q   <= 1'b0;
            VMEAddr   <= '0;
            VMEWrData <= '0;
            wb_dat_o  <= '0;
            VMERdMem  <= 1'b0;
            VMEWrMem  <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            abort_q   <= abort_d;
            VMEAddr   <= addr_d;
            VMEWrData <= wdata_d;
            wb_dat_o  <= rdata_d;
            VMERdMem  <= rd_d;
            VMEWrMem  <= wr_d;
            wb_ack_o  <= ack_d;
            wb_err_o  <= err_d;
            timeout_o <= to_d;
        end
    end

endmodule

// File: tb/tb_wb_vme_strobe_bridge.sv
// tb/tb_wb_vme_strobe_bridge.sv - randomized self-checking bench for wb_vme_strobe_bridge
module tb_wb_vme_strobe_bridge;

    localparam int TO = 8;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]  wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [4:1]  VMEAddr;
    logic [15:0] VMEWrData;
    logic        VMERdMem, VMEWrMem;
    logic [15:0] VMERdData = '0;
    logic        VMERdDone = 1'b0, VMEWrDone = 1'b0;
    logic        timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model state: last written data and last read result.
    logic [15:0] m_wdata = '0;
    logic [15:0] m_dat   = '0;

    always #5 Clk = ~Clk;

    wb_vme_strobe_bridge #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(16),
        .TIMEOUT   (TO)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .VMEAddr  (VMEAddr),
        .VMEWrData(VMEWrData),
        .VMERdMem (VMERdMem),
        .VMEWrMem (VMEWrMem),
        .VMERdData(VMERdData),
        .VMERdDone(VMERdDone),
        .VMEWrDone(VMEWrDone),
        .timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_dat_o", wb_dat_o, 0);
        chk("rst_ack", wb_ack_o, 0);
        chk("rst_err", wb_err_o, 0);
        chk("rst_addr", VMEAddr, 0);
        chk("rst_wdata", VMEWrData, 0);
        chk("rst_rdmem", VMERdMem, 0);
        chk("rst_wrmem", VMEWrMem, 0);
        chk("rst_timeout", timeout_o, 0);
    endtask

    // Entered #1 after a rising edge with the bridge idle; returns the same way.
    // lat = cycles after the strobe cycle at which the slave answers (0 = in it).
    task automatic run_txn(input logic we, input logic [3:0] adr, input logic [15:0] dat,
                           input int lat, input logic [15:0] rd_val, input int wrong_mask,
                           input int drop_c, input logic keep);
        int   resp_c;
        logic ok, dropped;
        ok      = (lat <= TO);
        resp_c  = ok ? lat + 2 : TO + 2;
        dropped = (drop_c >= 1) && (drop_c < resp_c);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        @(negedge Clk);
        chk("idle_wrmem", VMEWrMem, 0);
        chk("idle_rdmem", VMERdMem, 0);
        chk("idle_ack", wb_ack_o, 0);
        chk("idle_err", wb_err_o, 0);
        chk("idle_dat_o", wb_dat_o, m_dat);
        if (we) m_wdata = dat;
        for (int c = 1; c <= resp_c; c++) begin
            @(posedge Clk);
            #1;
            VMERdDone = 1'b0;
            VMEWrDone = 1'b0;
            VMERdData = 16'($urandom);
            if (c == lat + 1) begin
                if (we) VMEWrDone = 1'b1;
                else begin
                    VMERdDone = 1'b1;
                    VMERdData = rd_val;
                end
            end
            if (c < resp_c && c < 32 && wrong_mask[c]) begin
                if (we) VMERdDone = 1'b1;
                else    VMEWrDone = 1'b1;
            end
            if (c == drop_c) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            @(negedge Clk);
            if (c == resp_c) begin
                if (!ok) m_dat = 16'h0;
                else if (!we) m_dat = rd_val;
            end
            chk("wrmem", VMEWrMem, (c == 1) && we);
            chk("rdmem", VMERdMem, (c == 1) && !we);
            chk("addr", VMEAddr, adr);
            chk("wdata", VMEWrData, m_wdata);
            chk("ack", wb_ack_o, (c == resp_c) && ok && !dropped);
            chk("err", wb_err_o, (c == resp_c) && !ok && !dropped);
            chk("timeout", timeout_o, (c == resp_c) && !ok);
            chk("dat_o", wb_dat_o, m_dat);
        end
        @(posedge Clk);
        #1;
        VMERdDone = 1'b0;
        VMEWrDone = 1'b0;
        if (!keep) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            chk("quiet_rdmem", VMERdMem, 0);
            chk("quiet_wrmem", VMEWrMem, 0);
            chk("quiet_ack", wb_ack_o, 0);
            chk("quiet_err", wb_err_o, 0);
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat, drop_c, resp_c;
        logic keep;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_all_zero();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        idle_cycles(2);

        run_txn(1'b1, 4'hB, 16'h00A5, 1, 16'h0, 0, 0, 1'b0);
        run_txn(1'b0, 4'h0, 16'h0, 1, 16'h0001, 0, 0, 1'b0);
        run_txn(1'b0, 4'h3, 16'h0, 99, 16'h0, 0, 0, 1'b0);
        run_txn(1'b0, 4'h5, 16'h0, 4, 16'h1234, 32'h4, 0, 1'b0);
        run_txn(1'b1, 4'hA, 16'h5A5A, 1, 16'h0, 0, 0, 1'b1);
        run_txn(1'b0, 4'hB, 16'h0, 1, 16'hBEEF, 0, 0, 1'b1);
        run_txn(1'b0, 4'h2, 16'h0, 1, 16'hC0DE, 0, 0, 1'b0);
        idle_cycles(2);
        run_txn(1'b0, 4'h7, 16'h0, 0, 16'h7777, 0, 0, 1'b0);
        run_txn(1'b1, 4'h8, 16'h1111, TO, 16'h0, 0, 0, 1'b0);
        run_txn(1'b0, 4'h9, 16'h0, TO + 1, 16'h9999, 0, 0, 1'b0);
        run_txn(1'b0, 4'hC, 16'h0, 3, 16'h4321, 0, 2, 1'b0);
        idle_cycles(1);

        // Reset while waiting for a Done that never comes.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 4'h6;
        wb_dat_i = 16'hDEAD;
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        Rst      = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge Clk);
        chk("pre_rst_in_wait", VMEAddr, 4'h6);
        @(posedge Clk);
        @(negedge Clk);
        chk_all_zero();
        @(posedge Clk);
        #1;
        Rst     = 1'b0;
        m_wdata = 16'h0;
        m_dat   = 16'h0;
        idle_cycles(TO + 4);
        run_txn(1'b0, 4'h1, 16'h0, 2, 16'hA5A5, 0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            lat    = ($urandom_range(0, 7) == 0) ? 50 : int'($urandom_range(0, TO + 1));
            resp_c = (lat <= TO) ? lat + 2 : TO + 2;
            drop_c = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, resp_c - 1)) : 0;
            keep   = (drop_c == 0) && ($urandom_range(0, 1) == 1);
            run_txn(1'($urandom), 4'($urandom), 16'($urandom), lat, 16'($urandom),
                    int'($urandom) & int'($urandom), drop_c, keep);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
